// File: rtl/lift_car_emulator.sv
// Behavioural lift car: integrates hoist commands into a car position, drives floor
// contact sensing and a door FSM, and flags controller movement-rule violations.
module lift_car_emulator #(
    parameter int N_FLOORS      = 12,
    parameter int T             = 200,
    parameter int T_FLR_CONTCT  = 50,
    parameter int DOOR_OPEN_REQ = 100,
    parameter int START_FLOOR   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                direction,
    input  logic                motion,
    input  logic                door_cmd,
    output logic [N_FLOORS-1:0] floor_sense,
    output logic [N_FLOORS-1:0] true_floor,
    output logic                at_floor,
    output logic                door_open,
    output logic [4:0]          violation,
    output logic                error
);

    localparam int PW = $clog2(T + 1) + 1;
    localparam int CW = (DOOR_OPEN_REQ > 1) ? $clog2(DOOR_OPEN_REQ) : 1;

    localparam logic signed [PW-1:0] POS_ONE    = PW'(1);
    localparam logic signed [PW-1:0] POS_TOP    = PW'(T);
    localparam logic signed [PW-1:0] POS_BOT    = -POS_TOP;
    localparam logic signed [PW-1:0] CONTACT_HI = PW'(T_FLR_CONTCT);
    localparam logic signed [PW-1:0] CONTACT_LO = -CONTACT_HI;
    localparam logic [N_FLOORS-1:0]  RESET_FLOOR = N_FLOORS'(1) << START_FLOOR;
    localparam logic [CW-1:0]        HOLD_LOAD   = CW'(DOOR_OPEN_REQ - 1);

    typedef enum logic [1:0] {
        DOOR_CLOSED,
        DOOR_OPEN,
        DOOR_HOLD_DONE
    } door_state_t;

    logic signed [PW-1:0] pos_q, pos_d, pos_step;
    logic [N_FLOORS-1:0]  true_floor_q, true_floor_d;
    logic [N_FLOORS-1:0]  floor_sense_q, floor_sense_d;
    logic                 at_floor_q, at_floor_d;
    door_state_t          door_state_q, door_state_d;
    logic                 door_open_q, door_open_d;
    logic [CW-1:0]        hold_cnt_q, hold_cnt_d;
    logic [4:0]           violation_q, violation_d;
    logic                 error_q, error_d;
    logic                 direction_q, door_cmd_q;
    logic                 overrun, motion_ok, in_contact;
    logic [4:0]           viol_now;

    // An overrun is only possible when level at an end floor, so the shift never wraps.
    always_comb begin
        overrun   = (pos_q == '0) &&
                    ((direction && true_floor_q[N_FLOORS-1]) || (!direction && true_floor_q[0]));
        motion_ok = motion && !door_open_q && !overrun;
        pos_step  = direction ? (pos_q + POS_ONE) : (pos_q - POS_ONE);

        pos_d        = pos_q;
        true_floor_d = true_floor_q;
        if (motion_ok) begin
            if (pos_step == POS_TOP) begin
                pos_d        = '0;
                true_floor_d = true_floor_q << 1;
            end else if (pos_step == POS_BOT) begin
                pos_d        = '0;
                true_floor_d = true_floor_q >> 1;
            end else begin
                pos_d = pos_step;
            end
        end

        in_contact    = (pos_d <= CONTACT_HI) && (pos_d >= CONTACT_LO);
        floor_sense_d = in_contact ? true_floor_d : '0;
        at_floor_d    = (pos_d == '0);
    end

    always_comb begin
        door_state_d = door_state_q;
        hold_cnt_d   = hold_cnt_q;
        case (door_state_q)
            DOOR_CLOSED: begin
                if (door_cmd && at_floor_q && !motion) begin
                    hold_cnt_d = HOLD_LOAD;
                    if (DOOR_OPEN_REQ > 1) begin
                        door_state_d = DOOR_OPEN;
                    end else begin
                        door_state_d = DOOR_HOLD_DONE;
                    end
                end
            end
            DOOR_OPEN: begin
                // Leave OPEN on the cycle the countdown lands on zero.
                if (hold_cnt_q <= CW'(1)) begin
                    door_state_d = DOOR_HOLD_DONE;
                    hold_cnt_d   = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q - CW'(1);
                end
            end
            DOOR_HOLD_DONE: begin
                if (!door_cmd) begin
                    door_state_d = DOOR_CLOSED;
                end
            end
            default: begin
                door_state_d = DOOR_CLOSED;
            end
        endcase
        door_open_d = (door_state_d != DOOR_CLOSED);
    end

    always_comb begin
        viol_now    = '0;
        viol_now[0] = motion && (pos_q != '0) && (direction != direction_q);
        viol_now[1] = !motion && (pos_q != '0);
        viol_now[2] = motion && overrun;
        viol_now[3] = (motion && door_open_q) ||
                      (door_cmd && !door_cmd_q && (motion || (pos_q != '0)));
        viol_now[4] = (door_state_q == DOOR_OPEN) && !door_cmd;
        violation_d = violation_q | viol_now;
        error_d     = |viol_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q         <= '0;
            true_floor_q  <= RESET_FLOOR;
            floor_sense_q <= RESET_FLOOR;
            at_floor_q    <= 1'b1;
            door_state_q  <= DOOR_CLOSED;
            door_open_q   <= 1'b0;
            hold_cnt_q    <= '0;
            violation_q   <= '0;
            error_q       <= 1'b0;
            direction_q   <= 1'b0;
            door_cmd_q    <= 1'b0;
        end else begin
            pos_q         <= pos_d;
            true_floor_q  <= true_floor_d;
            floor_sense_q <= floor_sense_d;
            at_floor_q    <= at_floor_d;
            door_state_q  <= door_state_d;
            door_open_q   <= door_open_d;
            hold_cnt_q    <= hold_cnt_d;
            violation_q   <= violation_d;
            error_q       <= error_d;
            direction_q   <= direction;
            door_cmd_q    <= door_cmd;
        end
    end

    assign floor_sense = floor_sense_q;
    assign true_floor  = true_floor_q;
    assign at_floor    = at_floor_q;
    assign door_open   = door_open_q;
    assign violation   = violation_q;
    assign error       = error_q;

endmodule

// File: doc/lift_car_emulator.md
# lift_car_emulator

Testbench-side behavioural model of one lift car: hoist position, floor contact sensors and car door. It integrates the controller's `direction`/`motion`/`door_cmd` outputs into a cycle-accurate car position and drives one-hot floor sensing back to the controller under test. It also checks the movement rules that the previous emulator only listed as comments; each violation sets a sticky flag and raises a one-cycle error pulse for the scoreboard.

## Interface
- `N_FLOORS`, 12: number of floors; bit 0 = ground, bit N_FLOORS-1 = top.
- `T`, 200: clocks of motion per floor-to-floor travel.
- `T_FLR_CONTCT`, 50: half-width of the floor contact zone, in clocks.
- `DOOR_OPEN_REQ`, 100: minimum clocks the door stays open once opened.
- `START_FLOOR`, 0: floor index loaded at reset; legal range 0..N_FLOORS-1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `direction` input 1: 1 = up, 0 = down.
- `motion` input 1: hoist drive enable.
- `door_cmd` input 1: 1 = request door open, 0 = request close.
- `floor_sense` output N_FLOORS: one-hot floor contact, all-zero between floors.
- `true_floor` output N_FLOORS: one-hot last floor reached.
- `at_floor` output 1: car exactly level (position count = 0).
- `door_open` output 1: door state.
- `violation` output 5: sticky rule-violation flags.
- `error` output 1: one-cycle pulse on any new violation event.

## Operation
- State: signed position count `pos` with range -(T-1)..T-1, one-hot `true_floor`, door FSM, door hold counter sized for DOOR_OPEN_REQ.
- Reset (async, `rst_n`=0): `pos`=0, `true_floor`=1<<START_FLOOR, `floor_sense`=`true_floor`, `at_floor`=1, `door_open`=0, `violation`=0, `error`=0, door FSM in CLOSED.
- Movement is qualified as motion_ok = `motion` & !`door_open` & !overrun. Overrun is when `pos`=0 and either `direction`=1 with top bit set or `direction`=0 with bit 0 set.
- If motion_ok: `pos` steps +1 (up) or -1 (down). On reaching +T, `true_floor` shifts left and `pos`=0. On reaching -T, it shifts right and `pos`=0.
- If !motion_ok: `pos` holds. The car may stall mid-shaft; this is legal to model but flagged.
- `floor_sense` = `true_floor` when |`pos`| <= T_FLR_CONTCT, otherwise all zeros. It is registered and reflects the post-update `pos`.
- Door FSM:
  - CLOSED -> OPEN when `door_cmd`=1, `at_floor`=1 and `motion`=0. The hold counter loads DOOR_OPEN_REQ-1.
  - OPEN -> HOLD_DONE when the counter reaches 0.
  - HOLD_DONE -> CLOSED when `door_cmd`=0.
  - `door_cmd` while moving or off-level is ignored and flagged.
- Violation bits, each set on the cycle its condition is sampled true:
  - [0] DIR_CHANGE: `direction` toggles while `motion`=1 and `pos`!=0.
  - [1] MID_STOP: `motion`=0 with `pos`!=0 while `rst_n` high.
  - [2] OVERRUN: `motion`=1 and overrun.
  - [3] DOOR_MOTION: `motion`=1 while `door_open`=1, or `door_cmd` rises while `motion`=1 or `pos`!=0.
  - [4] DOOR_EARLY: `door_cmd`=0 while the FSM is in OPEN (hold not expired). The door stays open regardless.
- `error` = OR of this cycle's violation conditions, registered. It pulses every cycle a condition holds, even if the sticky bit is already set.
- `true_floor` is one-hot by construction. Shifts at the ends are impossible because the overrun gate applies at `pos`=0.

## Timing
- All outputs are registered; input effects are visible one clock after the sampling edge.
- From `pos`=0, continuous motion: `floor_sense` drops after T_FLR_CONTCT+1 motion cycles. `true_floor`/`floor_sense` show the new floor exactly T motion cycles after motion starts.
- Reversal mid-span (flagged): `pos` walks back. Crossing 0 continues to -T toward the floor below.
- `door_open` rises 1 clock after the qualifying `door_cmd`. It remains high for at least DOOR_OPEN_REQ cycles and falls 1 clock after `door_cmd`=0 in HOLD_DONE.
- Async reset mid-travel returns the car immediately to START_FLOOR with `pos`=0. This is not a violation.
- Violation flags clear only on reset.

## Test plan
- Reset with START_FLOOR=0, motion up for 200 clocks -> `floor_sense`=0 from clock 51, `true_floor`=12'h002 at clock 200, `violation`=0.
- At floor 0, hold direction=0 with motion=1 for 5 clocks -> `pos` stays 0, `true_floor`=12'h001, `violation[2]`=1, `error` high 5 cycles.
- Motion up 80 clocks, then drop motion -> `pos` holds 80, `floor_sense`=0, `violation[1]`=1.
- Motion up 30 clocks, toggle direction, run 60 clocks -> `violation[0]`=1, `pos`=-30, `floor_sense`=12'h001, `true_floor`=12'h001.
- At floor, pulse door_cmd 10 clocks -> `door_open` high 100 clocks then falls; `violation[4]`=1. Repeat with motion=1 while open -> `pos` stays 0, `violation[3]`=1.
- Deassert `rst_n` at motion clock 120 -> asynchronous return to `true_floor`=1<<START_FLOOR, all flags 0, `door_open`=0.
